wb_stage_buf: RTL and testbench
===============================

// Module: wb_stage_buf
// PURPOSE
//  Parametrised MEM->WB stage buffer for the multi-issue pipeline: replaces the single-entry
//  MEM/WB latch with a DEPTH-entry FIFO of LANES-wide write-back bundles.
//  Uses a valid/ready handshake plus flush.
//  Sanitises each bundle on entry: x0 writes dropped, same-rd conflicts resolved.
//  Sits between the MEM stage and the register-file write ports.
// PARAMETERS
//  LANES   2   write-back lanes per bundle (>=1); lane LANES-1 is the youngest instruction
//  DATA_W  32  register data width
//  ADDR_W  5   register address width
//  DEPTH   2   bundle entries (power of two, >=1)
// PORTS
//  clk        in   1              clock, all state updates on rising edge
//  rst        in   1              asynchronous, active-low reset
//  flush      in   1              discard all buffered and incoming bundles
//  in_valid   in   1              MEM offers a bundle
//  in_ready   out  1              buffer accepts; = (count < DEPTH)
//  in_rd      in   LANES*ADDR_W   lane i dest at [i*ADDR_W +: ADDR_W]
//  in_wdata   in   LANES*DATA_W   lane i data at [i*DATA_W +: DATA_W]
//  in_wreg    in   LANES          lane i write enable
//  out_valid  out  1              head bundle present; = (count != 0)
//  out_ready  in   1              WB/regfile consumes head this cycle
//  out_rd     out  LANES*ADDR_W   head dests; all-zero when empty
//  out_wdata  out  LANES*DATA_W   head data; all-zero when empty
//  out_wreg   out  LANES          head write enables; all-zero when empty
//  count      out  $clog2(DEPTH+1) occupancy
// BEHAVIOUR
//  Reset (rst==0, async): count=0, read and write pointers=0, storage contents don't-care.
//   All outputs then read zero/NOP except in_ready=1.
//  Push when in_valid&&in_ready&&!flush; pop when out_valid&&out_ready&&!flush.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//   in_ready depends only on count, with no combinational path from out_ready.
//   A full buffer therefore refuses input even if it pops that cycle.
//  Latency: a bundle pushed at edge N is visible on out_* after edge N.
//   That bundle is the head if the buffer was empty.
//   out_* are driven from storage at rd_ptr and are gated to zero when count==0.
//  Pointers are $clog2(DEPTH)-bit and wrap modulo DEPTH.
//   For DEPTH==1, both pointers are constant 0.
//  Sanitise, applied combinationally before storage, on the written entry only:
//   1) in_wreg[i] && in_rd[i]==0 -> stored wreg[i]=0.
//   2) For i<j, in_wreg[i]&&in_wreg[j]&&in_rd[i]==in_rd[j] -> stored wreg[i]=0 (youngest wins).
//   rd and wdata of a suppressed lane are stored unchanged.
//  A bundle with every wreg=0 after sanitising is still pushed, occupying a slot; it is not a bubble.
//  Flush (synchronous, 1 cycle): count=0, pointers=0.
//   The same-cycle push is dropped and the same-cycle pop is ignored.
//   in_ready is 1 on the next cycle.
//  Flush has priority over push/pop; reset has priority over flush.
//   Reset asserted mid-stream discards all entries immediately.
//  Full (count==DEPTH): in_ready=0. Holding in_valid with unchanged in_* is legal.
//  Empty: out_valid=0, out_* zero; out_ready is ignored.
//  count never exceeds DEPTH and never underflows.
// TESTING
//  1) Release reset, idle -> out_valid=0, out_rd/out_wdata/out_wreg=0, in_ready=1, count=0.
//  2) Push {lane0:rd=3,wd=0x11,we=1; lane1:rd=4,wd=0x22,we=1} with out_ready=1 -> next cycle
//     out_valid=1 with the same bundle; following cycle count=0.
//  3) out_ready=0, push 3 bundles A,B,C with DEPTH=2 -> A,B accepted, in_ready=0 with C held.
//     Raise out_ready -> A, then B, then C emerge in order; count stays <=2.
//  4) Push lane0 {rd=0,we=1} and lane1 {rd=7,we=1} -> out_wreg=2'b10.
//     Push lanes {rd=5,we=1},{rd=5,we=1} -> out_wreg=2'b10, out_wdata lane1 intact.
//  5) Two bundles buffered, assert flush together with in_valid=1 -> next cycle count=0,
//     out_valid=0, the incoming bundle is absent.
//  6) Drop rst asynchronously mid-cycle with count=2 -> outputs zero and count=0 before next edge.
//     Stream 2*DEPTH+1 bundles -> pointer wrap is exercised with data intact.

Source files
------------

// File: rtl/wb_stage_buf.sv
// ============================================================================
// Module      : wb_stage_buf
// Description : MEM->WB stage buffer, DEPTH-entry FIFO of LANES-wide
//               write-back bundles with entry-time write sanitising and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_buf #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*ADDR_W-1:0]      in_rd,
    input  logic [LANES*DATA_W-1:0]      in_wdata,
    input  logic [LANES-1:0]             in_wreg,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ADDR_W-1:0]      out_rd,
    output logic [LANES*DATA_W-1:0]      out_wdata,
    output logic [LANES-1:0]             out_wreg,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;

    logic [LANES*ADDR_W-1:0]    rd_mem_q    [DEPTH];
    logic [LANES*DATA_W-1:0]    wdata_mem_q [DEPTH];
    logic [LANES-1:0]           wreg_mem_q  [DEPTH];

    logic                       w_push;
    logic                       w_pop;
    logic                       w_not_empty;
    logic [LANES-1:0]           w_wreg_san;
    logic [LANES*ADDR_W-1:0]    w_head_rd;
    logic [LANES*DATA_W-1:0]    w_head_wdata;
    logic [LANES-1:0]           w_head_wreg;

    // in_ready is a pure function of occupancy, so a full buffer refuses
    // input even in a cycle where the head is being consumed.
    assign w_not_empty = (count_q != '0);
    assign in_ready    = (count_q < C_DEPTH_CNT);
    assign out_valid   = w_not_empty;
    assign count       = count_q;

    assign w_push = in_valid  && in_ready    && !flush;
    assign w_pop  = out_ready && w_not_empty && !flush;

    // Drop x0 writes, and let the youngest lane win a same-rd conflict.
    always_comb begin
        w_wreg_san = '0;
        for (int i = 0; i < LANES; i++) begin
            w_wreg_san[i] = in_wreg[i] && (in_rd[i*ADDR_W +: ADDR_W] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (in_wreg[j] &&
                    (in_rd[j*ADDR_W +: ADDR_W] == in_rd[i*ADDR_W +: ADDR_W])) begin
                    w_wreg_san[i] = 1'b0;
                end
            end
        end
    end

    generate
        if (DEPTH == 1) begin : g_ptr_single
            always_comb begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
        end else begin : g_ptr_multi
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observable while counted.
    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_push && (wr_ptr_q == PTR_W'(e))) begin
                    rd_mem_q[e]    <= in_rd;
                    wdata_mem_q[e] <= in_wdata;
                    wreg_mem_q[e]  <= w_wreg_san;
                end
            end
        end
    endgenerate

    always_comb begin
        w_head_rd    = '0;
        w_head_wdata = '0;
        w_head_wreg  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (rd_ptr_q == PTR_W'(e)) begin
                w_head_rd    = rd_mem_q[e];
                w_head_wdata = wdata_mem_q[e];
                w_head_wreg  = wreg_mem_q[e];
            end
        end
    end

    assign out_rd    = w_not_empty ? w_head_rd    : '0;
    assign out_wdata = w_not_empty ? w_head_wdata : '0;
    assign out_wreg  = w_not_empty ? w_head_wreg  : '0;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_buf.sv
// ============================================================================
// Module      : tb_wb_stage_buf
// Description : Directed + randomised scoreboard bench for wb_stage_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_buf;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] rd;
        logic [LANES*DATA_W-1:0] wdata;
        logic [LANES-1:0]        wreg;
    } bundle_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*ADDR_W-1:0]    in_rd;
    logic [LANES*DATA_W-1:0]    in_wdata;
    logic [LANES-1:0]           in_wreg;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*ADDR_W-1:0]    out_rd;
    logic [LANES*DATA_W-1:0]    out_wdata;
    logic [LANES-1:0]           out_wreg;
    logic [CNT_W-1:0]           count;

    bundle_t sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    wb_stage_buf #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_wdata  (in_wdata),
        .in_wreg   (in_wreg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_wdata (out_wdata),
        .out_wreg  (out_wreg),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference sanitiser: walk from the youngest lane down, a lane loses if
    // any younger enabled lane targets the same register.
    function automatic bundle_t model_bundle(input logic [LANES*ADDR_W-1:0] rd,
                                             input logic [LANES*DATA_W-1:0] wd,
                                             input logic [LANES-1:0] we);
        bundle_t b;
        b.rd    = rd;
        b.wdata = wd;
        b.wreg  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            logic shadowed;
            shadowed = 1'b0;
            for (int j = LANES - 1; j > i; j--)
                if (we[j] && rd[j*ADDR_W +: ADDR_W] == rd[i*ADDR_W +: ADDR_W]) shadowed = 1'b1;
            b.wreg[i] = we[i] && (rd[i*ADDR_W +: ADDR_W] != 0) && !shadowed;
        end
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        bundle_t exp;
        exp = (sb.size() != 0) ? sb[0] : '0;
        check({tag, ".count"},     128'(count),     128'(sb.size()));
        check({tag, ".out_valid"}, 128'(out_valid), 128'(sb.size() != 0));
        check({tag, ".in_ready"},  128'(in_ready),  128'(sb.size() < DEPTH));
        check({tag, ".head"},      128'({out_rd, out_wdata, out_wreg}), 128'(exp));
    endtask

    task automatic drive(input logic v,
                         input logic [ADDR_W-1:0] rd0, input logic [DATA_W-1:0] wd0, input logic we0,
                         input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] wd1, input logic we1);
        in_valid = v;
        in_rd    = {rd1, rd0};
        in_wdata = {wd1, wd0};
        in_wreg  = {we1, we0};
    endtask

    // One clock: predict from the inputs now applied, advance, compare.
    task automatic cycle(input string tag);
        bit      do_push, do_pop;
        bundle_t b;
        do_push = in_valid && (sb.size() < DEPTH) && !flush;
        do_pop  = out_ready && (sb.size() != 0) && !flush;
        b = model_bundle(in_rd, in_wdata, in_wreg);
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(b);
        end
        check_outputs(tag);
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs("reset_idle");
        cycle("idle");

        // Single bundle straight through.
        out_ready = 1'b1;
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1);
        cycle("single_push");
        check("single_push.bundle", 128'({out_rd, out_wdata, out_wreg}),
              128'({5'd4, 5'd3, 32'h22, 32'h11, 2'b11}));
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        cycle("single_pop");
        check("single_pop.count0", 128'(count), 128'(0));

        // Backpressure: A, B fill the buffer, C waits.
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 32'hA1, 1'b1);
        cycle("fill_A");
        drive(1'b1, 5'd6, 32'hB0, 1'b1, 5'd9, 32'hB1, 1'b0);
        cycle("fill_B");
        drive(1'b1, 5'd10, 32'hC0, 1'b0, 5'd11, 32'hC1, 1'b1);
        cycle("hold_C1");
        check("hold_C1.in_ready0", 128'(in_ready), 128'(0));
        cycle("hold_C2");
        out_ready = 1'b1;
        cycle("drain_A");
        cycle("drain_B_push_C");
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        cycle("drain_C");
        cycle("drained");

        // Sanitising.
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h66, 1'b1);
        cycle("san_x0");
        check("san_x0.wreg", 128'(out_wreg), 128'(2'b10));
        drive(1'b1, 5'd5, 32'h77, 1'b1, 5'd5, 32'h88, 1'b1);
        cycle("san_dup");
        check("san_dup.wreg", 128'(out_wreg), 128'(2'b10));
        check("san_dup.wdata1", 128'(out_wdata[DATA_W +: DATA_W]), 128'(32'h88));
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        cycle("san_drain");

        // Flush with a concurrent incoming bundle.
        out_ready = 1'b0;
        drive(1'b1, 5'd12, 32'hF0, 1'b1, 5'd13, 32'hF1, 1'b1);
        cycle("fl_fill1");
        drive(1'b1, 5'd14, 32'hF2, 1'b1, 5'd15, 32'hF3, 1'b1);
        cycle("fl_fill2");
        flush = 1'b1;
        drive(1'b1, 5'd16, 32'hF4, 1'b1, 5'd17, 32'hF5, 1'b1);
        cycle("flush");
        check("flush.count0", 128'(count), 128'(0));
        flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        cycle("post_flush");

        // Asynchronous reset mid-cycle with a full buffer.
        drive(1'b1, 5'd20, 32'hD0, 1'b1, 5'd21, 32'hD1, 1'b1);
        cycle("rst_fill1");
        drive(1'b1, 5'd22, 32'hD2, 1'b1, 5'd23, 32'hD3, 1'b1);
        cycle("rst_fill2");
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 sb.delete();
        check_outputs("rst_async");
        #1 rst = 1'b1;
        cycle("rst_release");

        // Stream 2*DEPTH+1 bundles to wrap the pointers.
        out_ready = 1'b1;
        for (int k = 0; k < 2*DEPTH + 1; k++) begin
            drive(1'b1, 5'(k + 1), 32'hC0DE_0000 + k, 1'b1,
                  5'(k + 8), 32'hBEEF_0000 + k, 1'b1);
            cycle("wrap");
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        cycle("wrap_drain");

        // Random traffic with small rd range to provoke conflicts.
        for (int k = 0; k < 60; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            drive(1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
            cycle("random");
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
